// File: rtl/sr_cmd_debounce_pkg.sv
// Shared constants for the SR latch command stage: FSM encodings and arbitration priority.
package sr_cmd_debounce_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SET  = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

    localparam bit PRI_CLR = 1'b0;
    localparam bit PRI_SET = 1'b1;

endpackage

// File: rtl/sr_cmd_debounce_ch.sv
// One input channel: two-flop synchroniser, persistence-counter debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
module sr_cmd_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level flips on the edge where the mismatch run would reach DEBOUNCE_CYCLES.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/sr_cmd_debounce.sv
// Command stage in front of the SR latch: debounces set/clear requests, arbitrates them
// and emits fixed-width, mutually exclusive s/r pulses separated by at least one idle cycle.
module sr_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 2,
    parameter int SET_PRIORITY    = 0,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);
    import sr_cmd_debounce_pkg::*;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic          set_level, set_rise, clr_level, clr_rise;
    logic          levels_unused;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
    logic          s_q, r_q, busy_q, conflict_q, conflict_d;

    sr_cmd_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
        .clk(clk), .reset(reset), .din(set_in), .level(set_level), .rise(set_rise)
    );

    sr_cmd_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr (
        .clk(clk), .reset(reset), .din(clr_in), .level(clr_level), .rise(clr_rise)
    );

    assign levels_unused = set_level ^ clr_level;

    // New rises always fold into the pending bits; IDLE consumes them. Leaving a hold
    // always passes through IDLE, which provides the mandatory idle gap.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pend_set_d = pend_set_q | set_rise;
        pend_clr_d = pend_clr_q | clr_rise;
        conflict_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (pend_set_d && pend_clr_d) begin
                    conflict_d = 1'b1;
                    pend_set_d = 1'b0;
                    pend_clr_d = 1'b0;
                    state_d    = (SET_PRIORITY == int'(PRI_SET)) ? ST_SET : ST_CLR;
                end else if (pend_set_d) begin
                    pend_set_d = 1'b0;
                    state_d    = ST_SET;
                end else if (pend_clr_d) begin
                    pend_clr_d = 1'b0;
                    state_d    = ST_CLR;
                end
            end
            ST_SET, ST_CLR: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_q        <= (state_d == ST_SET);
            r_q        <= (state_d == ST_CLR);
            busy_q     <= (state_d != ST_IDLE);
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce: clear-wins and set-wins instances driven in parallel
// from a per-cycle vector table, plus reset-mid-pulse and randomised invariant sequences.
module tb_sr_cmd_debounce;

    localparam int DEB  = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic reset;
    logic set_in, clr_in;
    logic s0, r0, busy0, conf0;
    logic s1, r1, busy1, conf1;

    always #5 clk = ~clk;

    sr_cmd_debounce #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .SET_PRIORITY(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(s0), .r(r0), .busy(busy0), .conflict(conf0)
    );

    sr_cmd_debounce #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .SET_PRIORITY(1), .CNT_W(3)) u_dut1 (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(s1), .r(r1), .busy(busy1), .conflict(conf1)
    );

    // Expected outputs packed as {s, r, busy, conflict}; e0 clear-wins, e1 set-wins.
    typedef struct {
        string      tag;
        logic       set_v;
        logic       clr_v;
        logic [3:0] e0;
        logic [3:0] e1;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic add_vec(input string tag, input logic sv, input logic cv,
                           input logic [3:0] e0, input logic [3:0] e1);
        vec_t v;
        v.tag = tag; v.set_v = sv; v.clr_v = cv; v.e0 = e0; v.e1 = e1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic add_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) add_vec(tag, 1'b0, 1'b0, 4'b0000, 4'b0000);
    endtask

    // Property monitor for the random phase, per instance.
    logic       mon_on = 1'b0;
    logic [1:0] ps = '0, pr = '0;
    int         run[2];
    int         viol[2];
    int         pulses[2];

    always @(negedge clk) begin
        logic [1:0] sv, rv, bv, cv;
        sv = {s1, s0}; rv = {r1, r0}; bv = {busy1, busy0}; cv = {conf1, conf0};
        if (reset) assert (!(s0 && r0) && !(s1 && r1)) else $error("s and r high together");
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                if (sv[d] && rv[d]) viol[d]++;
                if (bv[d] != (sv[d] | rv[d])) viol[d]++;
                if ((ps[d] && rv[d]) || (pr[d] && sv[d])) viol[d]++;
                if (cv[d] && !((sv[d] | rv[d]) && !(ps[d] | pr[d]))) viol[d]++;
                if (sv[d] | rv[d]) begin
                    if (!(ps[d] | pr[d])) pulses[d]++;
                    run[d]++;
                end else begin
                    if ((ps[d] | pr[d]) && run[d] != HOLD) viol[d]++;
                    run[d] = 0;
                end
            end
        end
        ps = sv;
        pr = rv;
    end

    initial begin
        for (int d = 0; d < 2; d++) begin run[d] = 0; viol[d] = 0; pulses[d] = 0; end
        set_in = 1'b0;
        clr_in = 1'b0;
        reset  = 1'b1;
        #3 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_dut0", {28'd0, s0, r0, busy0, conf0}, 32'd0);
        check("reset_dut1", {28'd0, s1, r1, busy1, conf1}, 32'd0);
        reset = 1'b1;

        // Clean set: s on relative edges 6 and 7.
        for (int i = 0; i < 10; i++)
            add_vec("clean", 1'b1, 1'b0, (i == 6 || i == 7) ? 4'b1010 : 4'b0000,
                    (i == 6 || i == 7) ? 4'b1010 : 4'b0000);
        add_idle("clean_fall", 8);
        // Bounce never persists long enough to flip the level.
        add_vec("bounce", 1'b1, 1'b0, 4'b0000, 4'b0000);
        add_vec("bounce", 1'b0, 1'b0, 4'b0000, 4'b0000);
        add_vec("bounce", 1'b1, 1'b0, 4'b0000, 4'b0000);
        add_idle("bounce", 9);
        // Simultaneous rises: clear wins on dut0, set wins on dut1.
        for (int i = 0; i < 10; i++)
            add_vec("simul", 1'b1, 1'b1,
                    (i == 6) ? 4'b0111 : (i == 7) ? 4'b0110 : 4'b0000,
                    (i == 6) ? 4'b1011 : (i == 7) ? 4'b1010 : 4'b0000);
        add_idle("simul_fall", 8);
        // Clear qualifies during the set hold: s, s, idle, r, r.
        add_vec("b2b", 1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 1; i < 12; i++)
            add_vec("b2b", 1'b1, 1'b1,
                    (i == 6 || i == 7) ? 4'b1010 : (i == 9 || i == 10) ? 4'b0110 : 4'b0000,
                    (i == 6 || i == 7) ? 4'b1010 : (i == 9 || i == 10) ? 4'b0110 : 4'b0000);
        add_idle("b2b_fall", 8);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in = vecs[i].set_v;
            clr_in = vecs[i].clr_v;
            @(posedge clk); #1;
            check($sformatf("%s[%0d]_dut0", vecs[i].tag, i), {28'd0, s0, r0, busy0, conf0}, {28'd0, vecs[i].e0});
            check($sformatf("%s[%0d]_dut1", vecs[i].tag, i), {28'd0, s1, r1, busy1, conf1}, {28'd0, vecs[i].e1});
        end

        // Reset mid-pulse, then re-qualification with set_in still high.
        set_in = 1'b1;
        for (int n = 0; n < 20 && !s0; n++) begin
            @(posedge clk); #1;
        end
        check("rst_pre_s", {31'd0, s0}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_async_dut0", {28'd0, s0, r0, busy0, conf0}, 32'd0);
        check("rst_async_dut1", {28'd0, s1, r1, busy1, conf1}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i <= DEB + 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_relat[%0d]_dut0", i), {30'd0, s0, r0}, (i == DEB + 2) ? 32'd2 : 32'd0);
            check($sformatf("rst_relat[%0d]_dut1", i), {30'd0, s1, r1}, (i == DEB + 2) ? 32'd2 : 32'd0);
        end
        set_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Random segments long and short enough to both qualify and bounce.
        mon_on = 1'b1;
        for (int c = 0; c < 10000; ) begin
            int len;
            len    = $urandom_range(1, 12);
            set_in = 1'($urandom_range(0, 1));
            clr_in = 1'($urandom_range(0, 1));
            repeat (len) @(posedge clk);
            #1;
            c += len;
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        mon_on = 1'b0;
        check("rnd_viol_dut0", viol[0], 32'd0);
        check("rnd_viol_dut1", viol[1], 32'd0);
        check("rnd_activity_dut0", {31'd0, pulses[0] > 20}, 32'd1);
        check("rnd_activity_dut1", {31'd0, pulses[1] > 20}, 32'd1);
        check("rnd_idle_end", {24'd0, s0, r0, busy0, conf0, s1, r1, busy1, conf1}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
